// File: rtl/fp_mul_pkg.sv
// Shared constants and inter-stage bundles
// for the multiplier normalise/round/pack stage.
package fp_mul_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int SIG_W   = MAN_W + 1;
  localparam int PROD_W  = 2 * SIG_W;
  localparam int E_W     = 10;
  localparam int RES_W   = 1 + EXP_W + MAN_W;
  localparam int EXP_MAX = 2 * BIAS + 1;

  typedef enum logic [1:0] {
    CLS_NORM = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } cls_e;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  localparam logic [RES_W-1:0] QNAN = 32'h7FC00000;

  typedef struct packed {
    logic                  sign;
    cls_e                  cls;
    logic signed [E_W-1:0] e;
    logic [MAN_W-1:0]      m;
    logic                  g;
    logic                  st;
  } s1_t;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic [3:0]       flags;
  } s2_t;

endpackage

// File: rtl/fp_norm_round_if.sv
// Product-in / result-out handshake bundle
// between the multiplier datapath and the rounding stage.
interface fp_norm_round_if;
  import fp_mul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [E_W-1:0]    in_exp;
  logic [PROD_W-1:0] in_mant;
  logic [1:0]        in_cls;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_result;
  logic [3:0]        out_flags;

  modport master (
    output in_valid,
    output in_sign,
    output in_exp,
    output in_mant,
    output in_cls,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_flags
  );

  modport slave (
    input  in_valid,
    input  in_sign,
    input  in_exp,
    input  in_mant,
    input  in_cls,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result,
    output out_flags
  );

endinterface

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even and binary32 packing
// of a normalised significand, with exception flags.
module fp_rne_round
  import fp_mul_pkg::*;
(
  input  s1_t s1_i,
  output s2_t s2_o
);

  logic                  inc;
  logic [MAN_W:0]        sum;
  logic signed [E_W:0]   e_r;
  logic                  ovf;
  logic                  unf;

  always_comb begin
    inc = s1_i.g & (s1_i.st | s1_i.m[0]);
    sum = {1'b0, s1_i.m} + {{MAN_W{1'b0}}, inc};
    // one bit of headroom so a carry out of 254 never wraps
    e_r = {s1_i.e[E_W-1], s1_i.e}
        + {{E_W{1'b0}}, sum[MAN_W]};
    ovf = (e_r >= EXP_MAX);
    unf = (e_r <= 0);
  end

  always_comb begin
    s2_o = '0;
    unique case (s1_i.cls)
      CLS_NORM: begin
        s2_o.flags[FLG_INX] = s1_i.g | s1_i.st;
        unique case (1'b1)
          ovf: begin
            s2_o.result = {s1_i.sign, {EXP_W{1'b1}},
                           {MAN_W{1'b0}}};
            s2_o.flags[FLG_OVF] = 1'b1;
            s2_o.flags[FLG_INX] = 1'b1;
          end
          unf: begin
            s2_o.result = {s1_i.sign, {(RES_W-1){1'b0}}};
            s2_o.flags[FLG_UNF] = 1'b1;
            s2_o.flags[FLG_INX] = 1'b1;
          end
          default: begin
            s2_o.result = {s1_i.sign, e_r[EXP_W-1:0],
                           sum[MAN_W-1:0]};
          end
        endcase
      end
      CLS_ZERO: begin
        s2_o.result = {s1_i.sign, {(RES_W-1){1'b0}}};
      end
      CLS_INF: begin
        s2_o.result = {s1_i.sign, {EXP_W{1'b1}},
                       {MAN_W{1'b0}}};
      end
      default: begin
        s2_o.result = QNAN;
        s2_o.flags[FLG_INV] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalise / round / pack pipeline
// with valid/ready flow control, one result per cycle.
module fp_norm_round
  import fp_mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  fp_norm_round_if.slave  bus
);

  localparam int P = PROD_W;

  s1_t  s1_d;
  s1_t  s1_q;
  logic s1_valid_q;
  s2_t  s2_d;
  s2_t  s2_q;
  logic s2_valid_q;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv = !s2_valid_q || bus.out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  assign bus.in_ready   = s1_adv;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_result = s2_q.result;
  assign bus.out_flags  = s2_q.flags;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.in_sign;
    s1_d.cls  = cls_e'(bus.in_cls);
    s1_d.e    = bus.in_exp;
    if (s1_d.cls == CLS_NORM) begin
      if (bus.in_mant[P-1]) begin
        s1_d.m  = bus.in_mant[P-2 -: MAN_W];
        s1_d.g  = bus.in_mant[P-2-MAN_W];
        s1_d.st = |bus.in_mant[P-3-MAN_W:0];
        s1_d.e  = bus.in_exp + E_W'(1);
      end else begin
        s1_d.m  = bus.in_mant[P-3 -: MAN_W];
        s1_d.g  = bus.in_mant[P-3-MAN_W];
        s1_d.st = |bus.in_mant[P-4-MAN_W:0];
      end
    end
  end

  fp_rne_round u_round (
    .s1_i (s1_q),
    .s2_o (s2_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_q <= s2_d;
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: rounding,
// range limits, special classes, backpressure, reset.
module tb_fp_norm_round;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  fp_norm_round_if bus ();

  fp_norm_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic send_one(
    input  logic        s,
    input  logic [9:0]  e,
    input  logic [47:0] m,
    input  logic [1:0]  c,
    output logic [31:0] res,
    output logic [3:0]  flg,
    output int          lat
  );
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_sign   = s;
    bus.in_exp    = e;
    bus.in_mant   = m;
    bus.in_cls    = c;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = bus.out_result;
    flg = bus.out_flags;
  endtask

  task automatic test_reset;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 ||
        bus.out_flags !== 4'h0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: valid=%b res=%h flg=%b rdy=%b want 0 0 0 1",
               bus.out_valid, bus.out_result, bus.out_flags,
               bus.in_ready);
    end
  endtask

  task automatic test_basic;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    send_one(1'b0, 10'd128, 48'h630000000000, 2'b00, r, f, lat);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL latency: got %0d want 2", lat);
    end
    total++;
    if (r !== 32'h40460000 || f !== 4'b0000) begin
      bad++;
      $display("FAIL basic_lo: got %h/%b want 40460000/0000", r, f);
    end
    send_one(1'b0, 10'd128, 48'hC60000000000, 2'b00, r, f, lat);
    total++;
    if (r !== 32'h40C60000 || f !== 4'b0000) begin
      bad++;
      $display("FAIL basic_hi: got %h/%b want 40C60000/0000", r, f);
    end
  endtask

  task automatic test_rne;
    logic [47:0] mv [4] = '{48'h400000400000, 48'h400000C00000,
                            48'h400000600000, 48'h7FFFFFC00000};
    logic [31:0] rv [4] = '{32'h3F800000, 32'h3F800002,
                            32'h3F800001, 32'h40000000};
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      send_one(1'b0, 10'd127, mv[i], 2'b00, r, f, lat);
      total++;
      if (r !== rv[i] || f !== 4'b0001) begin
        bad++;
        $display("FAIL rne[%0d]: got %h/%b want %h/0001",
                 i, r, f, rv[i]);
      end
    end
  endtask

  task automatic test_range;
    logic        sv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [9:0]  ev [6] = '{10'd254, 10'd254, 10'd0,
                            10'h3F6, 10'd254, 10'd1};
    logic [47:0] mv [6] = '{48'h800000000000, 48'h7FFFFFC00000,
                            48'h400000000000, 48'h400000000000,
                            48'h400000000000, 48'h400000000000};
    logic [31:0] rv [6] = '{32'h7F800000, 32'h7F800000,
                            32'h80000000, 32'h00000000,
                            32'h7F000000, 32'h80800000};
    logic [3:0]  fv [6] = '{4'b0101, 4'b0101, 4'b0011,
                            4'b0011, 4'b0000, 4'b0000};
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      send_one(sv[i], ev[i], mv[i], 2'b00, r, f, lat);
      total++;
      if (r !== rv[i] || f !== fv[i]) begin
        bad++;
        $display("FAIL range[%0d]: got %h/%b want %h/%b",
                 i, r, f, rv[i], fv[i]);
      end
    end
  endtask

  task automatic test_special;
    logic        sv [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0]  cv [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic [31:0] rv [4] = '{32'h80000000, 32'hFF800000,
                            32'h7FC00000, 32'h7FC00000};
    logic [3:0]  fv [4] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000};
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      send_one(sv[i], 10'd5, 48'h400000600000, cv[i], r, f, lat);
      total++;
      if (r !== rv[i] || f !== fv[i]) begin
        bad++;
        $display("FAIL special[%0d]: got %h/%b want %h/%b",
                 i, r, f, rv[i], fv[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int          sent = 0;
    int          got = 0;
    logic        acc = 1'b0;
    logic        held = 1'b0;
    logic [31:0] hold_r = '0;
    logic [31:0] exp_r;
    logic        exp_rdy;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      if (acc) sent++;
      if (sent < 6) begin
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 10'(127 + sent);
        bus.in_mant  = 48'h400000000000 | (48'(sent) << 23);
        bus.in_cls   = 2'b00;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = (cyc >= 5);
      #1;
      if (cyc < 5) begin
        exp_rdy = (sent < 2);
        total++;
        if (bus.in_ready !== exp_rdy) begin
          bad++;
          $display("FAIL b2b_ready cyc%0d: got %b want %b",
                   cyc, bus.in_ready, exp_rdy);
        end
      end
      if (held) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== hold_r) begin
          bad++;
          $display("FAIL b2b_hold cyc%0d: got %b/%h want 1/%h",
                   cyc, bus.out_valid, bus.out_result, hold_r);
        end
      end
      held   = bus.out_valid && !bus.out_ready;
      hold_r = bus.out_result;
      acc    = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        exp_r = {1'b0, 8'(127 + got), 23'(got)};
        total++;
        if (bus.out_result !== exp_r || bus.out_flags !== 4'b0) begin
          bad++;
          $display("FAIL b2b_item%0d: got %h/%b want %h/0000",
                   got, bus.out_result, bus.out_flags, exp_r);
        end
        got++;
      end
    end
    bus.in_valid = 1'b0;
    total++;
    if (got != 6) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 6", got);
    end
  endtask

  task automatic test_reset_flush;
    int seen = 0;
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 10'h3FF;
    bus.in_mant   = 48'h0;
    bus.in_cls    = 2'b11;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
        bus.out_result !== 32'h7FC00000 || bus.out_flags !== 4'b1000) begin
      bad++;
      $display("FAIL flush_full: got %b/%b/%h/%b want 1/0/7fc00000/1000",
               bus.out_valid, bus.in_ready, bus.out_result,
               bus.out_flags);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 ||
        bus.out_flags !== 4'h0) begin
      bad++;
      $display("FAIL flush_async: got %b/%h/%b want 0/0/0",
               bus.out_valid, bus.out_result, bus.out_flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL flush_after: got %0d outputs want 0", seen);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.in_cls    = 2'b00;
    bus.out_ready = 1'b0;
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_basic;
    test_rne;
    test_range;
    test_special;
    test_back_to_back;
    test_reset_flush;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
